// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch stage.
// Issues word addresses to a one-cycle-latency instruction memory, registers
// the returned instruction for decode, absorbs decode stalls with a one-entry
// skid buffer and flushes on branch/jump redirects.
// Optional build macro FETCH_MISALIGN_CHK_EN adds the sticky misalign_o flag:
// a redirect to a non-word-aligned target halts all fetching until reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] im_addr_o,
  output logic        im_req_o,
  input  logic [31:0] im_data_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        valid_o
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN,
    HOLD,
    FLUSH
  } state_e;

  state_e      state_q, state_d;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        resp_pend_q, resp_pend_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  logic        issue;
  logic        resp_take;
  logic        halted;

`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_q, misalign_d;
  assign halted     = misalign_q;
  assign misalign_o = misalign_q;
`else
  logic        redir_lsb_unused;
  assign halted           = 1'b0;
  assign redir_lsb_unused = ^redirect_pc_i[1:0];
`endif

  // State register: tracks RUN / HOLD / FLUSH across cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: redirect forces one flush cycle; stall or a full skid holds.
  always_comb begin
    state_d = RUN;
    if (redirect_i) begin
      state_d = FLUSH;
    end else if (stall_i || skid_valid_d) begin
      state_d = HOLD;
    end
  end

  // FSM outputs: issue permission and whether the returning response is live.
  always_comb begin
    issue     = !rst_i && !redirect_i && !stall_i && !skid_valid_q && !halted;
    resp_take = resp_pend_q && (state_q != FLUSH);
    im_req_o  = issue;
    im_addr_o = {2'b00, fetch_pc_q[31:2]};
  end

  // Datapath next values: fetch PC, in-flight tracking, skid buffer, output.
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    resp_pend_d  = resp_pend_q;
    resp_pc_d    = resp_pc_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    inst_d       = inst_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
`ifdef FETCH_MISALIGN_CHK_EN
    misalign_d   = misalign_q;
`endif

    if (redirect_i) begin
      // Redirect wins over stall and issue; the response due next cycle is
      // dropped because resp_pend is cleared here.
      fetch_pc_d   = {redirect_pc_i[31:2], 2'b00};
      resp_pend_d  = 1'b0;
      skid_valid_d = 1'b0;
      valid_d      = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      if (redirect_pc_i[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
`endif
    end else begin
      resp_pend_d = issue;
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        resp_pc_d  = fetch_pc_q;
      end

      if (stall_i) begin
        // Output holds; a response landing now is parked in the skid entry.
        if (resp_take) begin
          skid_valid_d = 1'b1;
          skid_inst_d  = im_data_i;
          skid_pc_d    = resp_pc_q;
        end
      end else if (skid_valid_q) begin
        inst_d       = skid_inst_q;
        pc_d         = skid_pc_q;
        valid_d      = 1'b1;
        skid_valid_d = 1'b0;
      end else if (resp_take) begin
        inst_d  = im_data_i;
        pc_d    = resp_pc_q;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // Datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q   <= RESET_PC;
      resp_pend_q  <= 1'b0;
      resp_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= NOP_INST;
      skid_pc_q    <= '0;
      inst_q       <= NOP_INST;
      pc_q         <= '0;
      valid_q      <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      resp_pend_q  <= resp_pend_d;
      resp_pc_q    <= resp_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      inst_q       <= inst_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule
